// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, ROM address, {pc, instr} output buffer
// Optional halt/halted ports are built in when IFETCH_HALT_EN is defined.
module ifetch_unit #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef IFETCH_HALT_EN
  input  logic              halt,
  output logic              halted,
`endif
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [DATA_W-1:0] mem_instr [DEPTH];

  logic          pop;
  logic          push;
  logic          fetch_en;
  logic          issue;
  logic [CW:0]   occ_after;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;

`ifdef IFETCH_HALT_EN
  assign fetch_en = ~halt;
  assign halted   = halt & ~inflight & (count == '0);
`else
  assign fetch_en = 1'b1;
`endif

  assign instr_valid = (count != '0);
  assign instr       = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight;

  // Slots committed after this cycle: buffered + in flight - leaving now.
  assign occ_after = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = fetch_en & (occ_after < (CW+1)'(DEPTH));

  assign rom_address = redirect_valid ? redirect_pc : pc;

  assign wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= ADDR_W'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush buffer and drop the in-flight word; a coincident pop is void.
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      if (fetch_en) begin
        inflight    <= 1'b1;
        inflight_pc <= redirect_pc;
        pc          <= redirect_pc + ADDR_W'(1);
      end else begin
        inflight <= 1'b0;
        pc       <= redirect_pc;
      end
    end else begin
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end else begin
        inflight <= 1'b0;
      end
      if (push) begin
        mem_pc[wr_ptr]    <= inflight_pc;
        mem_instr[wr_ptr] <= rom_dout;
        wr_ptr            <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_dout = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
`ifdef IFETCH_HALT_EN
  logic              halt = 1'b0;
  logic              halted;
`endif

  int checks = 0;
  int failures = 0;
  logic sb_en = 1'b0;
  logic [ADDR_W-1:0] sb_q[$];

  typedef struct {
    logic              ready;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] exp_rom;
  } vec_t;
  vec_t tv [17];

  always #5 clk = ~clk;

  // Program ROM stand-in: mem[i] = 0xA0000000 + i, registered address.
  always @(posedge clk) rom_dout <= 32'hA000_0000 + {22'b0, rom_address};

  ifetch_unit dut (
    .clk(clk),
    .reset(reset),
    .rom_address(rom_address),
    .rom_dout(rom_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
`ifdef IFETCH_HALT_EN
    .halt(halt),
    .halted(halted),
`endif
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_load(input logic [ADDR_W-1:0] base, input int n);
    sb_q.delete();
    for (int k = 0; k < n; k++) sb_q.push_back(base + ADDR_W'(k));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected instructions left after %0d cycles, required 0", name, sb_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction outside redirect/reset cycles.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] e;
    if (sb_en && !reset && !redirect_valid && instr_valid && instr_ready && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_pc", 32'(instr_pc), 32'(e));
      check("sb_instr", instr, 32'hA000_0000 + 32'(e));
    end
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] last;

    tv = '{
      '{1'b1, 1'b0, 10'd0, 10'd0},  '{1'b1, 1'b0, 10'd0, 10'd1},
      '{1'b1, 1'b1, 10'd0, 10'd2},  '{1'b1, 1'b1, 10'd1, 10'd3},
      '{1'b1, 1'b1, 10'd2, 10'd4},  '{1'b1, 1'b1, 10'd3, 10'd5},
      '{1'b1, 1'b1, 10'd4, 10'd6},  '{1'b1, 1'b1, 10'd5, 10'd7},
      '{1'b0, 1'b1, 10'd6, 10'd8},  '{1'b0, 1'b1, 10'd6, 10'd8},
      '{1'b0, 1'b1, 10'd6, 10'd8},  '{1'b0, 1'b1, 10'd6, 10'd8},
      '{1'b0, 1'b1, 10'd6, 10'd8},  '{1'b1, 1'b1, 10'd6, 10'd8},
      '{1'b1, 1'b1, 10'd7, 10'd9},  '{1'b1, 1'b1, 10'd8, 10'd10},
      '{1'b1, 1'b1, 10'd9, 10'd11}
    };

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Cycle-exact startup, steady stream and 5-cycle stall at pc 6.
    for (int c = 0; c < 17; c++) begin
      instr_ready = tv[c].ready;
      @(negedge clk);
      check("tv_valid", 32'(instr_valid), 32'(tv[c].exp_valid));
      check("tv_rom_address", 32'(rom_address), 32'(tv[c].exp_rom));
      if (c == 0) begin
        check("reset_instr", instr, 32'h0);
        check("reset_instr_pc", 32'(instr_pc), 32'h0);
      end
      if (tv[c].exp_valid) begin
        check("tv_instr_pc", 32'(instr_pc), 32'(tv[c].exp_pc));
        check("tv_instr", instr, 32'hA000_0000 + 32'(tv[c].exp_pc));
      end
      next_cycle();
    end

    // Fill the buffer, then redirect near the top of the address space.
    instr_ready = 1'b0;
    repeat (3) next_cycle();
    sb_load(10'h3FE, 4);
    redirect_valid = 1'b1;
    redirect_pc = 10'h3FE;
    instr_ready = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    check("redir_rom_address", 32'(rom_address), 32'h3FE);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid_drop", 32'(instr_valid), 32'h0);
    wait_drain(5, "redir_wrap");

    // Back-to-back redirects: only the second target streams.
    sb_load(10'h100, 4);
    redirect_valid = 1'b1;
    redirect_pc = 10'h100;
    next_cycle();
    sb_load(10'h200, 4);
    redirect_pc = 10'h200;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_valid_drop", 32'(instr_valid), 32'h0);
    wait_drain(5, "redir_b2b");

    // One-cycle reset mid-stream.
    sb_load(10'd0, 3);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid_drop", 32'(instr_valid), 32'h0);
    check("rst_rom_address", 32'(rom_address), 32'h0);
    wait_drain(5, "reset_restart");

`ifdef IFETCH_HALT_EN
    sb_en = 1'b0;
    n = 0;
    while (!(instr_valid && instr_pc == 10'd10) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("halt_reach_pc10", 32'(instr_pc), 32'd10);
    halt = 1'b1;
    last = 10'd10;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (halted) break;
      if (instr_valid && instr_ready) begin
        n++;
        last = instr_pc;
      end
    end
    check("halted", 32'(halted), 32'h1);
    checks++;
    if (n > 2) begin
      failures++;
      $display("FAIL halt_drain: got %0d instructions after halt, required at most 2", n);
    end
    next_cycle();
    halt = 1'b0;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("halt_resume_pc", 32'(instr_pc), 32'(last + 10'd1));
`else
    n = 0;
    last = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the 1024x32 program ROM.
- Owns the program counter and drives the ROM address.
- Captures the ROM read data one cycle later and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and sustains one instruction per cycle when decode is always ready.

Parameters:
ADDR_W, 10, ROM word-address width; PC width
DATA_W, 32, instruction width
RESET_PC, 0, PC loaded on reset
DEPTH, 2, output buffer entries (minimum 2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rom_address  output  ADDR_W  to ROM address input; ROM registers it, so data returns next cycle
rom_dout  input  DATA_W  ROM read data, valid the cycle after an address is presented
redirect_valid  input  1  load new PC this cycle
redirect_pc  input  ADDR_W  target PC
instr_valid  output  1  head of buffer valid
instr_ready  input  1  decode accepts head this cycle
instr  output  DATA_W  instruction at buffer head
instr_pc  output  ADDR_W  PC of instr

Behaviour:
- Clock is clk; reset is synchronous and active-high; no other clock or reset.
- State: pc register; inflight bit plus inflight_pc; DEPTH-entry FIFO of {pc, instr}; occupancy count 0..DEPTH.
- Reset values: pc=RESET_PC, inflight=0, FIFO empty, instr_valid=0, instr/instr_pc=0, rom_address=RESET_PC.
- pop = instr_valid & instr_ready.
- issue = (count + inflight - pop) < DEPTH.
- rom_address:
  - redirect_pc when redirect_valid=1;
  - pc otherwise (combinational).
- On issue with no redirect:
  - inflight<=1; inflight_pc<=pc;
  - pc<=pc+1, modulo 2^ADDR_W (1023 wraps to 0).
- When no issue: pc holds and inflight<=0. The ROM still reads the address, but that data is never captured.
- Capture: when inflight=1 (and no redirect this cycle), push {inflight_pc, rom_dout} into the FIFO.
- Push and pop in the same cycle are legal; count is unchanged. Overflow cannot occur because of the issue rule.
- FIFO outputs are registered from storage, with no bypass from rom_dout:
  - latency address-issue to instr_valid = 2 cycles;
  - first instr_valid after reset deassert is in cycle 2 (reset released at cycle 0 edge).
- Redirect has priority over everything:
  - FIFO flushed (count<=0);
  - current inflight data discarded;
  - a pop coinciding with redirect is ignored; decode must discard it;
  - fetch of redirect_pc issued that cycle; inflight<=1, inflight_pc<=redirect_pc;
  - pc<=redirect_pc+1 (wraps);
  - instr_valid falls the next cycle; redirect target appears at instr_valid two cycles after redirect.
- Back-to-back redirects: each cancels the previous; only the last target's stream is delivered.
- Steady state with instr_ready=1: one instruction per cycle, consecutive pcs.
- Backpressure: with instr_ready=0, fetch stops once count+inflight=DEPTH. Nothing is lost or duplicated on resume.
- Reset mid-operation discards FIFO and inflight; ROM data returned in the cycle after reset is ignored.
- instr/instr_pc hold stable while instr_valid=1 and instr_ready=0.

Optional Feature:
- Macro: IFETCH_HALT_EN.
- Defined:
  - adds input port halt (1 bit) and output port halted (1 bit, reset 0);
  - halt=1 forces issue=0; inflight and FIFO drain normally;
  - halted=1 when halt=1 and inflight=0 and count=0;
  - redirect during halt updates pc but issues no fetch; pc<=redirect_pc, not +1.
- Not defined: ports absent, issue per the base rule only.

Test Plan:
- ROM preloaded mem[i]=0xA0000000+i, reset 2 cycles, instr_ready=1 -> instr_valid first high cycle 2 after reset release; pcs 0,1,2,... one per cycle with instr=0xA0000000+pc.
- instr_ready=0 for 5 cycles mid-stream at pc=6 -> instr holds pc 6, rom_address stops advancing, count=2; on release pcs 6,7,8 delivered with no gap or duplicate.
- redirect_valid with redirect_pc=0x3FE while FIFO full -> instr_valid low next cycle; then pcs 0x3FE, 0x3FF, 0x000, 0x001 (wrap).
- Redirect to 0x100 then to 0x200 on consecutive cycles, with instr_ready=1 -> no pc 0x100 delivered; stream starts at 0x200.
- reset asserted for one cycle mid-stream -> instr_valid=0 next cycle; stream restarts at RESET_PC with no stale instruction.
- IFETCH_HALT_EN: halt=1 at pc=10 -> at most 2 further instructions delivered, then halted=1; halt=0 resumes fetch at the next sequential pc.
